// File: rtl/prog_branch_lut.sv
// Programmable branch-target table: label -> jump PC, loaded at boot instead of hard-coded.
// Latency: lookup result registered, 1 cycle after lookup_req; writes land at the same edge.
// Backpressure: ready is low while the table is scrubbing (DEPTH cycles); strobes seen then are dropped.
// Optional miss counter enabled by defining PROG_BRANCH_LUT_STATS_EN.
module prog_branch_lut #(
  parameter int LABEL_W = 8,
  parameter int PC_W    = 12,
  parameter int DEPTH   = 64,
  parameter logic [PC_W-1:0] DEFAULT_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tbl_clear,
  input  logic               wr_en,
  input  logic [LABEL_W-1:0] wr_label,
  input  logic [PC_W-1:0]    wr_pc,
  input  logic               lookup_req,
  input  logic [LABEL_W-1:0] label,
  output logic               ready,
  output logic               lookup_valid,
  output logic [PC_W-1:0]    next_pc,
  output logic               hit,
  output logic [15:0]        miss_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LABEL_W:0] DEPTH_L = (LABEL_W + 1)'(DEPTH);
  localparam logic [AW-1:0]    LAST    = AW'(DEPTH - 1);

  typedef enum logic {INIT, IDLE} state_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     ptr, ptr_nxt;
  logic [PC_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]  vld;

  logic              accept, wr_ok, lk_ok, wr_in, lk_in;
  logic [AW-1:0]     wr_idx, lk_idx;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [PC_W-1:0]   ram_dat;
  logic [PC_W-1:0]   lk_pc;
  logic              lk_hit;

  // tbl_clear wins over any same-cycle write or lookup
  assign ready  = (state == IDLE);
  assign accept = ready & ~tbl_clear;
  assign wr_in  = ({1'b0, wr_label} < DEPTH_L);
  assign lk_in  = ({1'b0, label} < DEPTH_L);
  assign wr_idx = wr_label[AW-1:0];
  assign lk_idx = label[AW-1:0];
  assign wr_ok  = accept & wr_en & wr_in;
  assign lk_ok  = accept & lookup_req;

  // State and scrub pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next state plus the single RAM write port (scrub in INIT, user writes in IDLE)
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    ram_we    = 1'b0;
    ram_addr  = ptr;
    ram_dat   = DEFAULT_PC;
    case (state)
      INIT: begin
        ram_we  = 1'b1;
        ptr_nxt = ptr + AW'(1);
        if (ptr == LAST) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end
      end
      IDLE: begin
        ram_we   = wr_ok;
        ram_addr = wr_idx;
        ram_dat  = wr_pc;
        if (tbl_clear) begin
          state_nxt = INIT;
          ptr_nxt   = '0;
        end
      end
    endcase
  end

  // Target storage; deliberately not reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_dat;
  end

  // Per-entry valid bits: cleared by reset and by the scrub, set by writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (state == INIT) begin
      vld[ptr] <= 1'b0;
    end else if (wr_ok) begin
      vld[wr_idx] <= 1'b1;
    end
  end

  // Lookup result before the output register; same-cycle write to the same label bypasses the RAM
  always_comb begin
    lk_pc  = DEFAULT_PC;
    lk_hit = 1'b0;
    if (lk_in) begin
      if (wr_ok && (wr_idx == lk_idx)) begin
        lk_pc  = wr_pc;
        lk_hit = 1'b1;
      end else if (vld[lk_idx]) begin
        lk_pc  = mem[lk_idx];
        lk_hit = 1'b1;
      end
    end
  end

  // Output register; next_pc/hit hold when no lookup completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lookup_valid <= 1'b0;
      next_pc      <= '0;
      hit          <= 1'b0;
    end else begin
      lookup_valid <= lk_ok;
      if (lk_ok) begin
        next_pc <= lk_pc;
        hit     <= lk_hit;
      end
    end
  end

`ifdef PROG_BRANCH_LUT_STATS_EN
  logic [15:0] miss_q;

  // Saturating count of completed lookups that missed; restarted by a table clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_q <= '0;
    end else if (ready && tbl_clear) begin
      miss_q <= '0;
    end else if (lk_ok && !lk_hit && (miss_q != 16'hFFFF)) begin
      miss_q <= miss_q + 16'd1;
    end
  end

  assign miss_count = miss_q;
`else
  assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_prog_branch_lut.sv
// Randomized and directed stimulus against a table-level model of the branch LUT.
// Model updates on each rising edge; a compare process checks every falling edge.
// Literal checks pin both the DUT and the model at the scenario points.
module tb_prog_branch_lut;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tbl_clear = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_label = '0;
  logic [11:0] wr_pc = '0;
  logic        lookup_req = 1'b0;
  logic [7:0]  label = '0;
  logic        ready;
  logic        lookup_valid;
  logic [11:0] next_pc;
  logic        hit;
  logic [15:0] miss_count;

  int n_cmp = 0;
  int n_bad = 0;

  prog_branch_lut dut (
    .clk(clk), .rst_n(rst_n), .tbl_clear(tbl_clear),
    .wr_en(wr_en), .wr_label(wr_label), .wr_pc(wr_pc),
    .lookup_req(lookup_req), .label(label),
    .ready(ready), .lookup_valid(lookup_valid), .next_pc(next_pc),
    .hit(hit), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int  m_tgt [DEPTH];
  bit  m_vld [DEPTH];
  int  init_left = DEPTH;
  int  m_ready = 0, m_lv = 0, m_pc = 0, m_hit = 0, m_miss = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_left = DEPTH;
      m_lv = 0; m_pc = 0; m_hit = 0; m_miss = 0;
      foreach (m_vld[i]) m_vld[i] = 1'b0;
    end else begin
      m_lv = 0;
      if (init_left > 0) begin
        init_left = init_left - 1;
      end else if (tbl_clear) begin
        init_left = DEPTH;
        m_miss = 0;
        foreach (m_vld[i]) m_vld[i] = 1'b0;
      end else begin
        if (lookup_req) begin
          m_lv = 1;
          if (int'(label) < DEPTH && wr_en && wr_label == label) begin
            m_pc = int'(wr_pc); m_hit = 1;
          end else if (int'(label) < DEPTH && m_vld[label]) begin
            m_pc = m_tgt[label]; m_hit = 1;
          end else begin
            m_pc = 0; m_hit = 0;
          end
          if (m_hit == 0 && m_miss < 65535) m_miss = m_miss + 1;
        end
        if (wr_en && int'(wr_label) < DEPTH) begin
          m_tgt[wr_label] = int'(wr_pc);
          m_vld[wr_label] = 1'b1;
        end
      end
    end
    m_ready = (init_left == 0) ? 1 : 0;
  end

  function automatic int exp_miss();
`ifdef PROG_BRANCH_LUT_STATS_EN
    return m_miss;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("ready", 32'(ready), 32'(m_ready));
    chk("lookup_valid", 32'(lookup_valid), 32'(m_lv));
    chk("next_pc", 32'(next_pc), 32'(m_pc));
    chk("hit", 32'(hit), 32'(m_hit));
    chk("miss_count", 32'(miss_count), 32'(exp_miss()));
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    wr_en = 1'b0; lookup_req = 1'b0; tbl_clear = 1'b0;
  endtask

  task automatic do_lookup(input int lb);
    lookup_req = 1'b1; label = 8'(lb);
    step();
  endtask

  task automatic do_write(input int lb, input int pc);
    wr_en = 1'b1; wr_label = 8'(lb); wr_pc = 12'(pc);
    step();
  endtask

  // DUT and model both pinned to hand-computed lookup results
  task automatic lit(input string nm, input int pc, input int h);
    chk({nm, "_valid"}, 32'(lookup_valid), 32'd1);
    chk({nm, "_pc"}, 32'(next_pc), 32'(pc));
    chk({nm, "_hit"}, 32'(hit), 32'(h));
    chk({nm, "_model_pc"}, 32'(m_pc), 32'(pc));
  endtask

  task automatic lit_miss(input string nm, input int v);
`ifdef PROG_BRANCH_LUT_STATS_EN
    chk(nm, 32'(miss_count), 32'(v));
    chk({nm, "_model"}, 32'(m_miss), 32'(v));
`else
    chk(nm, 32'(miss_count), 32'd0);
    if (v < 0) n_bad++;
`endif
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk(nm, 32'(n), 32'd64);
  endtask

  task automatic reset_vals(input string nm);
    chk({nm, "_ready"}, 32'(ready), 32'd0);
    chk({nm, "_lv"}, 32'(lookup_valid), 32'd0);
    chk({nm, "_pc"}, 32'(next_pc), 32'd0);
    chk({nm, "_hit"}, 32'(hit), 32'd0);
    chk({nm, "_miss"}, 32'(miss_count), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) step();
    reset_vals("rst");
    rst_n = 1'b1;
    wait_ready("init_len");

    // Unwritten entry
    do_lookup(5);
    lit("lk5", 0, 0);

    // Two writes then three back-to-back lookups
    do_write(2, 323);
    do_write(17, 620);
    do_lookup(2);
    lit("lk2", 323, 1);
    do_lookup(17);
    lit("lk17", 620, 1);
    do_lookup(3);
    lit("lk3", 0, 0);
    lit_miss("miss_after_lk3", 2);

    // Same-cycle write and lookup bypass
    wr_en = 1'b1; wr_label = 8'd9; wr_pc = 12'd267;
    do_lookup(9);
    lit("bypass9", 267, 1);

    // Out-of-range write is dropped, in-range entries untouched
    do_write(70, 100);
    do_lookup(70);
    lit("lk70", 0, 0);
    do_lookup(2);
    lit("lk2_again", 323, 1);
    do_lookup(6);
    lit("lk6", 0, 0);

    // Clear with a same-cycle lookup: lookup dropped, table re-scrubbed
    tbl_clear = 1'b1;
    do_lookup(2);
    chk("clr_no_valid", 32'(lookup_valid), 32'd0);
    chk("clr_ready_low", 32'(ready), 32'd0);
    wait_ready("clr_len");
    lit_miss("miss_after_clr", 0);
    do_lookup(2);
    lit("lk2_cleared", 0, 0);
    lit_miss("miss_restart", 1);

    // Random traffic, including out-of-range labels, collisions and clears
    for (int i = 0; i < 2000; i++) begin
      wr_en      = 1'($urandom_range(0, 1));
      wr_label   = 8'($urandom_range(0, 71));
      wr_pc      = 12'($urandom_range(0, 4095));
      lookup_req = ($urandom_range(0, 3) != 0);
      label      = ($urandom_range(0, 2) == 0) ? wr_label : 8'($urandom_range(0, 71));
      tbl_clear  = ($urandom_range(0, 299) == 0);
      step();
    end

    if (ready !== 1'b1) wait_ready("rand_tail_init");

`ifdef PROG_BRANCH_LUT_STATS_EN
    // Saturation of the miss counter
    for (int i = 0; i < 65540; i++) do_lookup(70);
    lit_miss("miss_sat", 65535);
`endif

    // Reset in the middle of a scrub
    tbl_clear = 1'b1;
    step();
    repeat (20) step();
    chk("mid_init_ready", 32'(ready), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    reset_vals("mid_rst");
    step();
    rst_n = 1'b1;
    wait_ready("reinit_len");
    do_lookup(17);
    lit("lk17_after_rst", 0, 0);
    lit_miss("miss_after_rst", 1);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
